// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared types and constants for the H-bridge PWM driver.
// Holds the per-channel state encoding and the minimum legal period.
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RAMP_DN = 2'd2,
        DEAD    = 2'd3
    } chan_state_e;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/motor_pwm_chan.sv
// motor_pwm_chan: one H-bridge channel -- FSM, duty ramp, dead time, output regs.
// Ports: clk/rst, shared cnt_i/wrap_i/period_i, requests en_i/dir_i/duty_i,
//        registered drive out_a_o/out_b_o/pwm_o and busy_o.
module motor_pwm_chan
    import motor_pwm_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RAMP_STEP = 1,
    parameter int DEAD_PER  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             out_a_o,
    output logic             out_b_o,
    output logic             pwm_o,
    output logic             busy_o
);

    localparam int DW = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam logic [DW-1:0] DCNT_INIT = DW'(DEAD_PER - 1);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic             dir_q, dir_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             pwm_q, pwm_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             drive;

    // Saturating move toward goal; never overshoots or wraps.
    function automatic logic [CNT_W-1:0] ramp(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] goal
    );
        logic [CNT_W-1:0] diff;
        if (RAMP_STEP == 0) return goal;
        diff = (goal > cur) ? goal - cur : cur - goal;
        if (diff <= STEP) return goal;
        return (goal > cur) ? cur + STEP : cur - STEP;
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        dcnt_d  = dcnt_q;
        if (wrap_i) begin
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_d = RUN;
                        dir_d   = dir_i;
                        cur_d   = ramp('0, duty_i);
                    end
                end
                RUN: begin
                    if (!en_i || (dir_i != dir_q)) begin
                        state_d = RAMP_DN;
                        cur_d   = ramp(cur_q, '0);
                    end else begin
                        cur_d = ramp(cur_q, duty_i);
                    end
                end
                RAMP_DN: begin
                    cur_d = ramp(cur_q, '0);
                    if (cur_d == '0) begin
                        state_d = DEAD;
                        dcnt_d  = DCNT_INIT;
                    end
                end
                DEAD: begin
                    // Requests are only looked at once the dead time expires.
                    if (dcnt_q == '0) begin
                        if (en_i) begin
                            state_d = RUN;
                            dir_d   = dir_i;
                            cur_d   = ramp('0, duty_i);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q - DW'(1);
                    end
                end
            endcase
        end
    end

    // Outputs are registered from current state, so pwm trails cnt by one cycle.
    always_comb begin
        drive  = (state_q == RUN) || (state_q == RAMP_DN);
        pwm_d  = drive && ((cnt_i < cur_q) || (cur_q >= period_i));
        a_d    = drive && !dir_q;
        b_d    = drive && dir_q;
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            dir_q   <= 1'b0;
            dcnt_q  <= '0;
            pwm_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            dcnt_q  <= dcnt_d;
            pwm_q   <= pwm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
        end
    end

    assign out_a_o = a_q;
    assign out_b_o = b_q;
    assign pwm_o   = pwm_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: multi-channel PWM H-bridge driver with shared period counter.
// Ports: clk/rst, period, per-channel en/dir/duty in; out_a/out_b/pwm/busy, wrap out.
module motor_pwm_ctrl
    import motor_pwm_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 10,
    parameter int RAMP_STEP  = 1,
    parameter int DEAD_PER   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      period,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       dir,
    input  logic [N_CH*CNT_W-1:0] duty,
    output logic [N_CH-1:0]       out_a,
    output logic [N_CH-1:0]       out_b,
    output logic [N_CH-1:0]       pwm,
    output logic [N_CH-1:0]       busy,
    output logic                  wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] per_clamp;
    logic             wrap_q, wrap_d;

    // wrap_q is registered from next-state values so it is high exactly
    // while cnt_q == per_q-1; a new period only loads at that boundary.
    always_comb begin
        per_clamp = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
        if (wrap_q) begin
            cnt_d = '0;
            per_d = per_clamp;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            per_d = per_q;
        end
        wrap_d = (cnt_d == per_d - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            per_q  <= CNT_W'(DEF_PERIOD);
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        motor_pwm_chan #(
            .CNT_W    (CNT_W),
            .RAMP_STEP(RAMP_STEP),
            .DEAD_PER (DEAD_PER)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wrap_i  (wrap_q),
            .cnt_i   (cnt_q),
            .period_i(per_q),
            .en_i    (en[i]),
            .dir_i   (dir[i]),
            .duty_i  (duty[i*CNT_W +: CNT_W]),
            .out_a_o (out_a[i]),
            .out_b_o (out_b[i]),
            .pwm_o   (pwm[i]),
            .busy_o  (busy[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: directed bench for motor_pwm_ctrl, step-0 and step-2 builds.
// Per-period vector table plus hand sequences for period change and reset.
module tb_motor_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  period;
    logic [1:0]  en, dir;
    logic [15:0] duty;

    logic [1:0] oa_z, ob_z, pw_z, bz_z;
    logic [1:0] oa_s, ob_s, pw_s, bz_s;
    logic       wr_z, wr_s;
    logic       wrap_d1 = 1'b0;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    motor_pwm_ctrl #(
        .N_CH(2), .CNT_W(8), .DEF_PERIOD(10),
        .RAMP_STEP(0), .DEAD_PER(2)
    ) dut_z (
        .clk(clk), .rst(rst), .period(period),
        .en(en), .dir(dir), .duty(duty),
        .out_a(oa_z), .out_b(ob_z), .pwm(pw_z),
        .busy(bz_z), .wrap(wr_z)
    );

    motor_pwm_ctrl #(
        .N_CH(2), .CNT_W(8), .DEF_PERIOD(10),
        .RAMP_STEP(2), .DEAD_PER(2)
    ) dut_s (
        .clk(clk), .rst(rst), .period(period),
        .en(en), .dir(dir), .duty(duty),
        .out_a(oa_s), .out_b(ob_s), .pwm(pw_s),
        .busy(bz_s), .wrap(wr_s)
    );

    always @(posedge clk) wrap_d1 <= wr_z;

    always @(negedge clk)
        if (rst !== 1'b1 &&
            (((oa_z & ob_z) | (oa_s & ob_s)) != 2'b00))
            overlap <= overlap + 1;

    typedef struct {
        logic       en0;
        logic       dir0;
        int         d0;
        int         per;
        int         len;
        int         wz;
        int         ws;
        logic [2:0] oz;
        logic [2:0] os;
    } vec_t;

    localparam int NV = 25;
    vec_t tv [NV];

    task automatic chk(input string nm, input int idx,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, want %0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic apply(input int i);
        en     = {1'b0, tv[i].en0};
        dir    = {1'b0, tv[i].dir0};
        duty   = {8'd0, 8'(tv[i].d0)};
        period = 8'(tv[i].per);
    endtask

    // Starts on the first sample of a period; ends on the first sample of
    // the next one, which carries this period's last pwm value.
    task automatic measure(output int len, output int wz, output int ws,
                           output logic [2:0] oz, output logic [2:0] os,
                           output logic c1z, output logic c1s);
        bit done;
        done = 0;
        len = 0; wz = 0; ws = 0;
        oz = '0; os = '0; c1z = 0; c1s = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            len++;
            wz += int'(pw_z[0]);
            ws += int'(pw_s[0]);
            c1z |= pw_z[1] | oa_z[1] | ob_z[1] | bz_z[1];
            c1s |= pw_s[1] | oa_s[1] | ob_s[1] | bz_s[1];
            if (wrap_d1) begin
                oz = {oa_z[0], ob_z[0], bz_z[0]};
                os = {oa_s[0], ob_s[0], bz_s[0]};
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL measure_timeout: got no wrap, want wrap");
        end
    endtask

    task automatic to_wrap(input int lim, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wr_z && k < lim);
    endtask

    initial begin
        int len, wz, ws, k;
        logic [2:0] oz, os;
        logic c1z, c1s;

        //          en dir d0  per len wz ws  oz      os
        tv[0]  = '{1, 0, 4,   10, 10, 4,  2,  3'b101, 3'b101};
        tv[1]  = '{1, 0, 8,   10, 10, 8,  4,  3'b101, 3'b101};
        tv[2]  = '{1, 0, 8,   10, 10, 8,  6,  3'b101, 3'b101};
        tv[3]  = '{1, 0, 8,   10, 10, 8,  8,  3'b101, 3'b101};
        tv[4]  = '{1, 0, 8,   10, 10, 8,  8,  3'b101, 3'b101};
        tv[5]  = '{1, 1, 8,   10, 10, 0,  6,  3'b101, 3'b101};
        tv[6]  = '{1, 1, 8,   10, 10, 0,  4,  3'b001, 3'b101};
        tv[7]  = '{1, 1, 8,   10, 10, 0,  2,  3'b001, 3'b101};
        tv[8]  = '{1, 1, 8,   10, 10, 8,  0,  3'b011, 3'b001};
        tv[9]  = '{1, 1, 8,   10, 10, 8,  0,  3'b011, 3'b001};
        tv[10] = '{1, 1, 8,   10, 10, 8,  2,  3'b011, 3'b011};
        tv[11] = '{1, 1, 8,   10, 10, 8,  4,  3'b011, 3'b011};
        tv[12] = '{1, 1, 8,   10, 10, 8,  6,  3'b011, 3'b011};
        tv[13] = '{1, 1, 8,   10, 10, 8,  8,  3'b011, 3'b011};
        tv[14] = '{0, 0, 8,   10, 10, 0,  6,  3'b011, 3'b011};
        tv[15] = '{1, 1, 8,   10, 10, 0,  4,  3'b001, 3'b011};
        tv[16] = '{0, 0, 8,   10, 10, 0,  2,  3'b001, 3'b011};
        tv[17] = '{0, 0, 8,   10, 10, 0,  0,  3'b000, 3'b001};
        tv[18] = '{0, 0, 8,   10, 10, 0,  0,  3'b000, 3'b001};
        tv[19] = '{0, 0, 8,   10, 10, 0,  0,  3'b000, 3'b000};
        tv[20] = '{1, 0, 200, 10, 10, 10, 2,  3'b101, 3'b101};
        tv[21] = '{1, 0, 200, 1,  2,  2,  2,  3'b101, 3'b101};
        tv[22] = '{1, 0, 1,   0,  2,  1,  2,  3'b101, 3'b101};
        tv[23] = '{1, 0, 1,   10, 10, 1,  1,  3'b101, 3'b101};
        tv[24] = '{1, 0, 0,   10, 10, 0,  0,  3'b101, 3'b101};

        rst = 1'b1;
        apply(0);
        repeat (3) @(negedge clk);
        chk("rst_z", 0, int'({pw_z, oa_z, ob_z, bz_z, wr_z}), 0);
        chk("rst_s", 0, int'({pw_s, oa_s, ob_s, bz_s, wr_s}), 0);
        rst = 1'b0;

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wrap_d1 && k < 50);
        chk("first_wrap", 0, k, 10);

        for (int i = 0; i < NV; i++) begin
            if (i + 1 < NV) apply(i + 1);
            measure(len, wz, ws, oz, os, c1z, c1s);
            chk("len", i, len, tv[i].len);
            chk("width_z", i, wz, tv[i].wz);
            chk("width_s", i, ws, tv[i].ws);
            chk("abz_z", i, int'(oz), int'(tv[i].oz));
            chk("abz_s", i, int'(os), int'(tv[i].os));
            chk("ch1_idle", i, int'({c1z, c1s}), 0);
        end

        // Period change mid-period must not truncate the running period.
        duty = {8'd0, 8'd4};
        repeat (4) @(negedge clk);
        period = 8'd6;
        to_wrap(50, k);
        chk("long_period", 0, k, 5);
        to_wrap(50, k);
        chk("short_period", 0, k, 6);

        // Reset in the middle of RUN, then restart at the first wrap.
        repeat (3) @(negedge clk);
        chk("busy_pre_rst", 0, int'(bz_z[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_z", 0, int'({pw_z, oa_z, ob_z, bz_z, wr_z}), 0);
        chk("mid_rst_s", 0, int'({pw_s, oa_s, ob_s, bz_s, wr_s}), 0);
        rst = 1'b0;
        to_wrap(50, k);
        chk("restart_wrap", 0, k, 9);
        chk("idle_to_wrap", 0, int'({bz_z, bz_s}), 0);
        @(negedge clk);
        measure(len, wz, ws, oz, os, c1z, c1s);
        chk("rs_len", 0, len, 6);
        chk("rs_width_z", 0, wz, 4);
        chk("rs_width_s", 0, ws, 2);
        chk("rs_abz_z", 0, int'(oz), 3'b101);
        chk("rs_abz_s", 0, int'(os), 3'b101);

        chk("no_overlap", 0, overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
